// File: rtl/reposicao_pkg.sv
// Shared types and default constants for the replenishment scheduler.
package reposicao_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StFill = 2'd1,
      StDone = 2'd2
   } state_e;

   localparam int unsigned FULL_LVL_DEF = 10;
   localparam int unsigned LOW_LVL_DEF  = 3;
   localparam int unsigned TIMEOUT_DEF  = 15;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr, wrapping.
module rr_arbiter #(
   parameter int unsigned N_SLOTS = 4,
   localparam int unsigned PTR_W  = $clog2(N_SLOTS)
) (
   input  logic [N_SLOTS-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [PTR_W-1:0]   grant,
   output logic               any_req
);

   int unsigned idx;

   // Scan from the farthest offset down so the nearest requester wins last.
   always_comb begin
      grant   = '0;
      idx     = 0;
      any_req = |req;
      for (int unsigned k = 0; k < N_SLOTS; k++) begin
         idx = (32'(rr_ptr) + (N_SLOTS - 1 - k)) % N_SLOTS;
         if (req[PTR_W'(idx)]) grant = PTR_W'(idx);
      end
   end

endmodule

// File: rtl/reposicao_controller.sv
// Replenishment scheduler: round-robin refill of low slots over a valid/ready supply port.
// Optional stall abort enabled by defining REPOSICAO_TIMEOUT_EN.
module reposicao_controller
   import reposicao_pkg::*;
#(
   parameter int unsigned N_SLOTS  = 4,
   parameter int unsigned QTY_W    = 4,
   parameter int unsigned FULL_LVL = FULL_LVL_DEF,
   parameter int unsigned LOW_LVL  = LOW_LVL_DEF,
   parameter int unsigned TIMEOUT  = TIMEOUT_DEF,
   localparam int unsigned PTR_W   = $clog2(N_SLOTS)
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [N_SLOTS*QTY_W-1:0] stock_lvl,
   input  logic                     supply_ready,
   output logic                     supply_valid,
   output logic [PTR_W-1:0]         supply_slot,
   output logic [QTY_W-1:0]         remaining,
   output logic                     busy,
   output logic                     done,
   output logic                     error
);

   state_e             state_q, state_d;
   logic [PTR_W-1:0]   slot_q, slot_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [QTY_W-1:0]   rem_q, rem_d;
   logic [N_SLOTS-1:0] req;
   logic [PTR_W-1:0]   grant;
   logic [QTY_W-1:0]   grant_lvl;
   logic               any_req;
   logic               hs;
   logic               timeout_hit;

   always_comb begin
      req       = '0;
      grant_lvl = '0;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
         req[i] = stock_lvl[i*QTY_W +: QTY_W] < QTY_W'(LOW_LVL);
         if (PTR_W'(i) == grant) grant_lvl = stock_lvl[i*QTY_W +: QTY_W];
      end
   end

   rr_arbiter #(
      .N_SLOTS (N_SLOTS)
   ) u_arb (
      .req     (req),
      .rr_ptr  (ptr_q),
      .grant   (grant),
      .any_req (any_req)
   );

   assign supply_valid = (state_q == StFill);
   assign busy         = (state_q != StIdle);
   assign done         = (state_q == StDone);
   assign supply_slot  = slot_q;
   assign remaining    = rem_q;
   assign hs           = supply_valid & supply_ready;

`ifdef REPOSICAO_TIMEOUT_EN
   localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

   logic [STALL_W-1:0] stall_q, stall_d;
   logic               err_q;

   // The cycle that would make the TIMEOUT-th consecutive stall aborts on its closing edge.
   assign timeout_hit = supply_valid && !supply_ready && (stall_q == STALL_W'(TIMEOUT - 1));

   always_comb begin
      stall_d = stall_q;
      if (!supply_valid || supply_ready) stall_d = '0;
      else                               stall_d = stall_q + STALL_W'(1);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         stall_q <= '0;
         err_q   <= 1'b0;
      end else begin
         stall_q <= stall_d;
         err_q   <= timeout_hit;
      end
   end

   assign error = err_q;
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT == 0);
   assign timeout_hit    = 1'b0;
   assign error          = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      rem_d   = rem_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               slot_d  = grant;
               rem_d   = QTY_W'(FULL_LVL) - grant_lvl;
               state_d = StFill;
            end
         end
         StFill: begin
            if (timeout_hit) begin
               state_d = StDone;
            end else if (hs) begin
               rem_d = rem_q - QTY_W'(1);
               if (rem_q == QTY_W'(1)) state_d = StDone;
            end
         end
         StDone: begin
            ptr_d   = (slot_q == PTR_W'(N_SLOTS - 1)) ? '0 : slot_q + PTR_W'(1);
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= StIdle;
         slot_q  <= '0;
         ptr_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
      end
   end

endmodule
